// File: rtl/apb4_splitter_pkg.sv
// Shared types and the priority address-decode function for the APB4 1-to-N splitter.
// The APB4_SPLITTER_SEC_CHK_EN option lives in apb4_splitter.sv; nothing here depends on it.
package apb4_splitter_pkg;

   localparam int MAX_SLV = 16;
   localparam int MAX_AW  = 64;
   localparam int IDX_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_TMO    = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             miss;
   } dec_res_t;

   // Walks from the top index down so the lowest matching window is the one left standing.
   function automatic dec_res_t win_decode(
      input logic [MAX_AW-1:0]         addr,
      input logic [MAX_SLV*MAX_AW-1:0] base,
      input logic [MAX_SLV*MAX_AW-1:0] mask,
      input int                        num_slv
   );
      dec_res_t r;
      r.idx  = '0;
      r.miss = 1'b1;
      for (int i = MAX_SLV - 1; i >= 0; i--) begin
         if ((i < num_slv) &&
             ((addr & mask[i*MAX_AW +: MAX_AW]) ==
              (base[i*MAX_AW +: MAX_AW] & mask[i*MAX_AW +: MAX_AW]))) begin
            r.idx  = IDX_W'(i);
            r.miss = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/apb4_addr_dec.sv
// Combinational priority decoder: maps PADDR onto the lowest-numbered matching slave window.
// Independent of APB4_SPLITTER_SEC_CHK_EN; the secure-slave filter is applied by the top.
module apb4_addr_dec
   import apb4_splitter_pkg::*;
#(
   parameter int                      NUM_SLV  = 4,
   parameter int                      ADDR_W   = 32,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
   input  logic [ADDR_W-1:0] paddr_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              miss_o
);

   logic [MAX_AW-1:0]         addr_x;
   logic [MAX_SLV*MAX_AW-1:0] base_x;
   logic [MAX_SLV*MAX_AW-1:0] mask_x;
   dec_res_t                  res;

   // Zero-extend everything to the package's fixed widths so one function serves all configurations.
   always_comb begin
      addr_x = '0;
      base_x = '0;
      mask_x = '0;
      addr_x[ADDR_W-1:0] = paddr_i;
      for (int i = 0; i < NUM_SLV; i++) begin
         base_x[i*MAX_AW +: ADDR_W] = SLV_BASE[i*ADDR_W +: ADDR_W];
         mask_x[i*MAX_AW +: ADDR_W] = SLV_MASK[i*ADDR_W +: ADDR_W];
      end
      res = win_decode(addr_x, base_x, mask_x, NUM_SLV);
   end

   assign idx_o  = res.idx;
   assign miss_o = res.miss;

endmodule

// File: rtl/apb4_splitter.sv
// APB4 1-to-N splitter: zero-latency decode, PSLVERR on unmapped addresses, access-phase timeout.
// Optional macro APB4_SPLITTER_SEC_CHK_EN: non-secure accesses to SLV_SECURE slaves become misses.
module apb4_splitter
   import apb4_splitter_pkg::*;
#(
   parameter int                        NUM_SLV    = 4,
   parameter int                        ADDR_W     = 32,
   parameter int                        DATA_W     = 32,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE   = '0,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK   = '0,
   parameter int                        TMO_CYCLES = 256,
   parameter logic [NUM_SLV-1:0]        SLV_SECURE = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [ADDR_W-1:0]        s_paddr_i,
   input  logic [2:0]               s_pprot_i,
   input  logic                     s_psel_i,
   input  logic                     s_penable_i,
   input  logic                     s_pwrite_i,
   input  logic [DATA_W-1:0]        s_pwdata_i,
   input  logic [DATA_W/8-1:0]      s_pstrb_i,
   output logic                     s_pready_o,
   output logic [DATA_W-1:0]        s_prdata_o,
   output logic                     s_pslverr_o,
   output logic [ADDR_W-1:0]        m_paddr_o,
   output logic [2:0]               m_pprot_o,
   output logic                     m_pwrite_o,
   output logic [DATA_W-1:0]        m_pwdata_o,
   output logic [DATA_W/8-1:0]      m_pstrb_o,
   output logic                     m_penable_o,
   output logic [NUM_SLV-1:0]       m_psel_o,
   input  logic [NUM_SLV-1:0]       m_pready_i,
   input  logic [NUM_SLV*DATA_W-1:0] m_prdata_i,
   input  logic [NUM_SLV-1:0]       m_pslverr_i,
   output logic                     tmo_o,
   output logic [1:0]               dbg_state_o
);

   localparam int               CNT_W    = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
   localparam bit               TMO_EN   = (TMO_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = (TMO_CYCLES > 0) ? CNT_W'(TMO_CYCLES - 1) : '0;

   // Handshake: a transfer is a setup cycle (psel & ~penable) followed by access cycles
   // (psel & penable); it completes on the first access cycle where pready is high, and
   // pslverr/prdata are only meaningful in that cycle.

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic               miss_q, miss_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   dec_idx;
   logic               dec_miss_raw;
   logic               dec_miss;
   logic               rdy_mux;
   logic               err_mux;
   logic [DATA_W-1:0]  data_mux;
   logic               resp_rdy;

   assign m_paddr_o   = s_paddr_i;
   assign m_pprot_o   = s_pprot_i;
   assign m_pwrite_o  = s_pwrite_i;
   assign m_pwdata_o  = s_pwdata_i;
   assign m_pstrb_o   = s_pstrb_i;
   assign m_penable_o = s_penable_i;
   assign dbg_state_o = state_q;

   apb4_addr_dec #(
      .NUM_SLV  (NUM_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .paddr_i (s_paddr_i),
      .idx_o   (dec_idx),
      .miss_o  (dec_miss_raw)
   );

`ifdef APB4_SPLITTER_SEC_CHK_EN
   logic sec_hit;

   always_comb begin
      sec_hit = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (dec_idx == IDX_W'(i)) sec_hit = SLV_SECURE[i];
      end
   end

   // pprot[1] set means a non-secure access.
   assign dec_miss = dec_miss_raw | (sec_hit & s_pprot_i[1]);
`else
   logic unused_sec;

   assign unused_sec = ^SLV_SECURE;
   assign dec_miss   = dec_miss_raw;
`endif

   always_comb begin
      rdy_mux  = 1'b0;
      err_mux  = 1'b0;
      data_mux = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_q == IDX_W'(i)) begin
            rdy_mux  = m_pready_i[i];
            err_mux  = m_pslverr_i[i];
            data_mux = m_prdata_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // A latched miss answers on its first access cycle, so it always counts as ready.
   assign resp_rdy = miss_q | rdy_mux;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         miss_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         miss_q  <= miss_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      miss_d      = miss_q;
      cnt_d       = cnt_q;
      m_psel_o    = '0;
      s_pready_o  = 1'b0;
      s_pslverr_o = 1'b0;
      s_prdata_o  = '0;
      tmo_o       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Setup is forwarded in the same cycle it is decoded.
            if (s_psel_i && !s_penable_i) begin
               state_d = ST_ACCESS;
               sel_d   = dec_idx;
               miss_d  = dec_miss;
               cnt_d   = '0;
               for (int i = 0; i < NUM_SLV; i++) begin
                  m_psel_o[i] = !dec_miss && (dec_idx == IDX_W'(i));
               end
            end
         end

         ST_ACCESS: begin
            if (!s_psel_i) begin
               state_d = ST_IDLE;
            end else begin
               for (int i = 0; i < NUM_SLV; i++) begin
                  m_psel_o[i] = !miss_q && (sel_q == IDX_W'(i));
               end
               if (miss_q) begin
                  s_pready_o  = 1'b1;
                  s_pslverr_o = 1'b1;
               end else begin
                  s_pready_o  = rdy_mux;
                  s_pslverr_o = err_mux;
                  s_prdata_o  = data_mux;
               end

               if (s_penable_i && resp_rdy) begin
                  state_d = ST_IDLE;
               end else if (TMO_EN && (cnt_q == CNT_LAST) && !resp_rdy) begin
                  state_d = ST_TMO;
               end else if (s_penable_i && !resp_rdy && (cnt_q != {CNT_W{1'b1}})) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_TMO: begin
            // Slave is already deselected here, so any late pready it raises goes nowhere.
            s_pready_o  = 1'b1;
            s_pslverr_o = 1'b1;
            tmo_o       = 1'b1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_apb4_splitter.sv
// Directed plus randomized bench for apb4_splitter, checked against a window/transfer reference model.
// Build with or without APB4_SPLITTER_SEC_CHK_EN; the model follows the same macro.
module tb_apb4_splitter;
   import apb4_splitter_pkg::*;

   localparam int NUM_SLV = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TMO_CYC = 8;
   localparam logic [NUM_SLV-1:0] SLV_SEC = 4'b0001;
   // Slave3's window also covers 0x2xxx_xxxx, where slave2 must win.
   localparam logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

   logic                      clk_i = 1'b0;
   logic                      rst_n_i;
   logic [ADDR_W-1:0]         s_paddr_i;
   logic [2:0]                s_pprot_i;
   logic                      s_psel_i;
   logic                      s_penable_i;
   logic                      s_pwrite_i;
   logic [DATA_W-1:0]         s_pwdata_i;
   logic [DATA_W/8-1:0]       s_pstrb_i;
   logic                      s_pready_o;
   logic [DATA_W-1:0]         s_prdata_o;
   logic                      s_pslverr_o;
   logic [ADDR_W-1:0]         m_paddr_o;
   logic [2:0]                m_pprot_o;
   logic                      m_pwrite_o;
   logic [DATA_W-1:0]         m_pwdata_o;
   logic [DATA_W/8-1:0]       m_pstrb_o;
   logic                      m_penable_o;
   logic [NUM_SLV-1:0]        m_psel_o;
   logic [NUM_SLV-1:0]        m_pready_i;
   logic [NUM_SLV*DATA_W-1:0] m_prdata_i;
   logic [NUM_SLV-1:0]        m_pslverr_i;
   logic                      tmo_o;
   logic [1:0]                dbg_state_o;

   int n_vec = 0;
   int n_err = 0;

   apb4_splitter #(
      .NUM_SLV    (NUM_SLV),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK),
      .TMO_CYCLES (TMO_CYC),
      .SLV_SECURE (SLV_SEC)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .s_paddr_i   (s_paddr_i),
      .s_pprot_i   (s_pprot_i),
      .s_psel_i    (s_psel_i),
      .s_penable_i (s_penable_i),
      .s_pwrite_i  (s_pwrite_i),
      .s_pwdata_i  (s_pwdata_i),
      .s_pstrb_i   (s_pstrb_i),
      .s_pready_o  (s_pready_o),
      .s_prdata_o  (s_prdata_o),
      .s_pslverr_o (s_pslverr_o),
      .m_paddr_o   (m_paddr_o),
      .m_pprot_o   (m_pprot_o),
      .m_pwrite_o  (m_pwrite_o),
      .m_pwdata_o  (m_pwdata_o),
      .m_pstrb_o   (m_pstrb_o),
      .m_penable_o (m_penable_o),
      .m_psel_o    (m_psel_o),
      .m_pready_i  (m_pready_i),
      .m_prdata_i  (m_prdata_i),
      .m_pslverr_i (m_pslverr_i),
      .tmo_o       (tmo_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: lowest window that matches, optionally filtered by the secure rule
   function automatic int model_target(input logic [31:0] a, input logic [2:0] prot);
      int t;
      t = -1;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (t < 0 && ((a & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])))
            t = i;
      end
`ifdef APB4_SPLITTER_SEC_CHK_EN
      if (t >= 0 && SLV_SEC[t] && prot[1]) t = -1;
`else
      if (prot[1] === 1'bx) t = -1;
`endif
      return t;
   endfunction

   // driver: random slave side, with the addressed slave forced to the wanted response
   task automatic drive_slaves(input int tgt, input bit rdy, input logic [31:0] rd, input bit err);
      m_pready_i  = 4'($urandom);
      m_pslverr_i = 4'($urandom);
      for (int i = 0; i < NUM_SLV; i++) m_prdata_i[i*32 +: 32] = $urandom;
      if (tgt >= 0) begin
         m_pready_i[tgt]          = rdy;
         m_pslverr_i[tgt]         = err;
         m_prdata_i[tgt*32 +: 32] = rd;
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk_i);
      s_psel_i    = 1'b0;
      s_penable_i = 1'b0;
      drive_slaves(-1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("idle_psel", m_psel_o, 0);
      chk("idle_pready", s_pready_o, 0);
      chk("idle_tmo", tmo_o, 0);
   endtask

   // waits < 0 means the slave never answers
   task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] prot,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits,
                       input bit idle_after);
      int         tgt;
      bit         err;
      bit         done;
      bit         rdy;
      logic [3:0] exp_sel;
      tgt     = model_target(addr, prot);
      err     = bit'($urandom_range(0, 1));
      exp_sel = (tgt >= 0) ? 4'(1 << tgt) : 4'h0;

      @(negedge clk_i);
      s_paddr_i   = addr;
      s_pprot_i   = prot;
      s_pwrite_i  = wr;
      s_pwdata_i  = wd;
      s_pstrb_i   = 4'($urandom);
      s_psel_i    = 1'b1;
      s_penable_i = 1'b0;
      drive_slaves(tgt, bit'($urandom_range(0, 1)), rd, err);
      #1;
      chk("setup_psel", m_psel_o, exp_sel);
      chk("setup_pready", s_pready_o, 0);
      chk("setup_tmo", tmo_o, 0);
      chk("bcast_paddr", m_paddr_o, addr);
      chk("bcast_pwdata", m_pwdata_o, wd);
      chk("bcast_ctl", {m_pwrite_o, m_pprot_o, m_pstrb_o, m_penable_o}, {wr, prot, s_pstrb_i, 1'b0});

      done = 1'b0;
      for (int k = 0; k <= TMO_CYC && !done; k++) begin
         @(negedge clk_i);
         s_penable_i = 1'b1;
         rdy = (waits >= 0) && (k >= waits);
         drive_slaves(tgt, rdy, rd, err);
         #1;
         if (tgt < 0) begin
            chk("miss_resp", {s_pready_o, s_pslverr_o, s_prdata_o}, {1'b1, 1'b1, 32'h0});
            chk("miss_psel", m_psel_o, 0);
            done = 1'b1;
         end else if (k == TMO_CYC) begin
            chk("tmo_resp", {s_pready_o, s_pslverr_o, s_prdata_o}, {1'b1, 1'b1, 32'h0});
            chk("tmo_pulse", tmo_o, 1);
            chk("tmo_psel", m_psel_o, 0);
            done = 1'b1;
         end else if (rdy) begin
            chk("done_resp", {s_pready_o, s_pslverr_o, s_prdata_o}, {1'b1, err, rd});
            chk("done_psel", m_psel_o, exp_sel);
            chk("done_tmo", tmo_o, 0);
            done = 1'b1;
         end else begin
            chk("wait_pready", s_pready_o, 0);
            chk("wait_psel", m_psel_o, exp_sel);
            chk("wait_bcast_en", m_penable_o, 1);
         end
      end
      if (idle_after) idle_cycle();
   endtask

   initial begin
      rst_n_i     = 1'b0;
      s_paddr_i   = 32'h1000_0000;
      s_pprot_i   = 3'b000;
      s_psel_i    = 1'b1;
      s_penable_i = 1'b1;
      s_pwrite_i  = 1'b0;
      s_pwdata_i  = 32'h0;
      s_pstrb_i   = 4'h0;
      drive_slaves(-1, 1'b0, 32'h0, 1'b0);
      #2;
      chk("rst_psel", m_psel_o, 0);
      chk("rst_resp", {s_pready_o, s_pslverr_o, s_prdata_o, tmo_o}, 35'h0);
      chk("rst_state", dbg_state_o, ST_IDLE);
      chk("rst_bcast", m_paddr_o, 32'h1000_0000);
      repeat (2) @(negedge clk_i);
      s_psel_i    = 1'b0;
      s_penable_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // zero-wait write to slave1, then slave2 read with 3 wait states
      xfer(32'h1000_0004, 1'b1, 3'b000, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);
      xfer(32'h2000_0000, 1'b0, 3'b000, 32'h0, 32'h1234_5678, 3, 1'b1);
      // unmapped, overlap priority, slave3 window
      xfer(32'hF000_0000, 1'b0, 3'b000, 32'h0, 32'h5555_AAAA, 0, 1'b1);
      xfer(32'h2ABC_1234, 1'b0, 3'b000, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
      xfer(32'h3000_0010, 1'b1, 3'b000, 32'h0BAD_CAFE, 32'h0, 2, 1'b1);
      // slave0 hangs, then back-to-back transfer to slave1
      xfer(32'h0000_0040, 1'b0, 3'b000, 32'h0, 32'h1111_2222, -1, 1'b0);
      xfer(32'h1000_0100, 1'b0, 3'b000, 32'h0, 32'h3333_4444, 0, 1'b1);
      // timeout boundary: ready on the last counted cycle vs. in the abort cycle
      xfer(32'h1000_0200, 1'b0, 3'b000, 32'h0, 32'h7777_8888, TMO_CYC - 1, 1'b0);
      xfer(32'h1000_0300, 1'b0, 3'b000, 32'h0, 32'h9999_0000, TMO_CYC, 1'b0);
      xfer(32'hF000_0000, 1'b1, 3'b000, 32'h1, 32'h0, 0, 1'b0);
      xfer(32'h3000_0000, 1'b0, 3'b000, 32'h0, 32'hABCD_EF01, 0, 1'b1);

      // asynchronous reset during slave3 wait states
      @(negedge clk_i);
      s_paddr_i   = 32'h3000_0040;
      s_psel_i    = 1'b1;
      s_penable_i = 1'b0;
      drive_slaves(3, 1'b0, 32'h0, 1'b0);
      repeat (3) begin
         @(negedge clk_i);
         s_penable_i = 1'b1;
         drive_slaves(3, 1'b0, 32'h0, 1'b0);
      end
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("midrst_psel", m_psel_o, 0);
      chk("midrst_state", dbg_state_o, ST_IDLE);
      chk("midrst_resp", {s_pready_o, s_pslverr_o, tmo_o}, 3'b000);
      @(negedge clk_i);
      s_psel_i    = 1'b0;
      s_penable_i = 1'b0;
      rst_n_i     = 1'b1;
      xfer(32'h3000_0044, 1'b0, 3'b000, 32'h0, 32'h0F0F_0F0F, 2, 1'b1);

      // protection: non-secure then secure access to the secure slave0
      xfer(32'h0000_0100, 1'b0, 3'b010, 32'h0, 32'h2468_ACE0, 1, 1'b1);
      xfer(32'h0000_0100, 1'b0, 3'b000, 32'h0, 32'h1357_9BDF, 1, 1'b1);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  nib;
         logic [31:0] a;
         int          w;
         case ($urandom_range(0, 5))
            0: nib = 4'h0;
            1: nib = 4'h1;
            2: nib = 4'h2;
            3: nib = 4'h3;
            4: nib = 4'hF;
            default: nib = 4'($urandom);
         endcase
         a = {nib, 28'($urandom)};
         w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
         xfer(a, bit'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, w,
              bit'($urandom_range(0, 1)));
      end
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
